// File: rtl/cdb_writeback_arbiter.sv
// CDB write-back arbiter: per-FU result FIFOs feeding one
// round-robin Common Data Bus broadcast.
module cdb_writeback_arbiter #(
   parameter int NUM_FU     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int XLEN       = 32,
   parameter int TAG_W      = 6,
   localparam int SRC_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic [NUM_FU-1:0]       fu_valid_i,
   input  logic [NUM_FU*XLEN-1:0]  fu_result_i,
   input  logic [NUM_FU*TAG_W-1:0] fu_rd_p_i,
   input  logic [NUM_FU*TAG_W-1:0] fu_rob_tag_i,
   output logic [NUM_FU-1:0]       fu_stall_o,
   output logic                    cdb_valid_o,
   output logic [XLEN-1:0]         cdb_result_o,
   output logic [TAG_W-1:0]        cdb_rd_p_o,
   output logic [TAG_W-1:0]        cdb_rob_tag_o,
   output logic [SRC_W-1:0]        cdb_src_o,
   output logic                    overflow_err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = XLEN + 2 * TAG_W;

   logic [ENT_W-1:0] mem_q [NUM_FU][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q  [NUM_FU];
   logic [PTR_W-1:0] wr_d  [NUM_FU];
   logic [PTR_W-1:0] rd_q  [NUM_FU];
   logic [PTR_W-1:0] rd_d  [NUM_FU];
   logic [CNT_W-1:0] cnt_q [NUM_FU];
   logic [CNT_W-1:0] cnt_d [NUM_FU];
   logic [SRC_W-1:0] rr_q, rr_d;
   logic             ovf_q, ovf_d;

   logic [NUM_FU-1:0] ne;
   logic [NUM_FU-1:0] deq;
   logic [NUM_FU-1:0] acc;
   logic [SRC_W-1:0]  gnt;
   logic              any_ne;
   logic              cdb_vld;
   logic [ENT_W-1:0]  head;

   // Round-robin pick: first non-empty FIFO at or after rr_q.
   always_comb begin
      gnt    = '0;
      any_ne = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
         ne[k] = (cnt_q[k] != '0);
      end
      for (int i = 0; i < NUM_FU; i++) begin
         for (int k = 0; k < NUM_FU; k++) begin
            if (!any_ne && ne[k] &&
                ((int'(rr_q) + i) % NUM_FU == k)) begin
               any_ne = 1'b1;
               gnt    = SRC_W'(k);
            end
         end
      end
   end

   // Broadcast the granted head; all fields read zero when idle.
   always_comb begin
      cdb_vld = any_ne & ~flush_i & ~rst;
      head    = '0;
      deq     = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (cdb_vld && gnt == SRC_W'(k)) begin
            head   = mem_q[k][rd_q[k]];
            deq[k] = 1'b1;
         end
      end
   end

   assign cdb_valid_o   = cdb_vld;
   assign cdb_result_o  = head[ENT_W-1 -: XLEN];
   assign cdb_rd_p_o    = head[2*TAG_W-1 -: TAG_W];
   assign cdb_rob_tag_o = head[TAG_W-1:0];
   assign cdb_src_o     = cdb_vld ? gnt : '0;
   assign overflow_err_o = ovf_q;

   // Throttle issue one slot early: the op already in flight needs room.
   always_comb begin
      for (int k = 0; k < NUM_FU; k++) begin
         fu_stall_o[k] = ~rst &
            (cnt_q[k] >= CNT_W'(FIFO_DEPTH - 1));
      end
   end

   // FIFO pointer/count update, drop-on-full detection, flush.
   always_comb begin
      ovf_d = ovf_q;
      acc   = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         logic full;
         logic enq;
         full   = (cnt_q[k] == CNT_W'(FIFO_DEPTH));
         enq    = fu_valid_i[k] & ~flush_i;
         acc[k] = enq & (~full | deq[k]);
         if (enq && full && !deq[k]) begin
            ovf_d = 1'b1;
         end
         wr_d[k]  = wr_q[k] + PTR_W'(acc[k]);
         rd_d[k]  = rd_q[k] + PTR_W'(deq[k]);
         cnt_d[k] = cnt_q[k] + CNT_W'(acc[k]) - CNT_W'(deq[k]);
         if (flush_i) begin
            wr_d[k]  = '0;
            rd_d[k]  = '0;
            cnt_d[k] = '0;
         end
      end
   end

   // Pointer advances past the winner; flush restarts at FU 0.
   always_comb begin
      rr_d = rr_q;
      if (flush_i) begin
         rr_d = '0;
      end else if (cdb_vld) begin
         rr_d = (int'(gnt) == NUM_FU - 1) ? '0 : gnt + SRC_W'(1);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_FU; k++) begin
            wr_q[k]  <= '0;
            rd_q[k]  <= '0;
            cnt_q[k] <= '0;
         end
         rr_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_FU; k++) begin
            wr_q[k]  <= wr_d[k];
            rd_q[k]  <= rd_d[k];
            cnt_q[k] <= cnt_d[k];
         end
         rr_q  <= rr_d;
         ovf_q <= ovf_d;
      end
   end

   // Result storage; only accepted entries are written.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_FU; k++) begin
         if (acc[k]) begin
            mem_q[k][wr_q[k]] <= {fu_result_i[k*XLEN +: XLEN],
                                  fu_rd_p_i[k*TAG_W +: TAG_W],
                                  fu_rob_tag_i[k*TAG_W +: TAG_W]};
         end
      end
   end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: vector table, corner
// sequences and random traffic against a queue-based model.
module tb_cdb_writeback_arbiter;

   localparam int N  = 2;
   localparam int D  = 4;
   localparam int XL = 32;
   localparam int TW = 6;
   localparam int SW = 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            flush = 1'b0;
   logic [N-1:0]    v = '0;
   logic [N*XL-1:0] res = '0;
   logic [N*TW-1:0] rdp = '0;
   logic [N*TW-1:0] tag = '0;
   logic [N-1:0]    stall;
   logic            cvld;
   logic [XL-1:0]   cres;
   logic [TW-1:0]   crd;
   logic [TW-1:0]   ctag;
   logic [SW-1:0]   csrc;
   logic            err;

   cdb_writeback_arbiter #(
      .NUM_FU(N), .FIFO_DEPTH(D), .XLEN(XL), .TAG_W(TW)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .fu_valid_i(v), .fu_result_i(res),
      .fu_rd_p_i(rdp), .fu_rob_tag_i(tag),
      .fu_stall_o(stall), .cdb_valid_o(cvld),
      .cdb_result_o(cres), .cdb_rd_p_o(crd),
      .cdb_rob_tag_o(ctag), .cdb_src_o(csrc),
      .overflow_err_o(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [XL-1:0] r;
      logic [TW-1:0] d;
      logic [TW-1:0] t;
   } ent_t;

   ent_t mq [N][$];
   int   m_rr;
   logic m_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [N-1:0] last_stall = '0;
   int   obs0[$];
   logic saw_stall0 = 1'b0;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic set_fu(input int k, input logic [XL-1:0] r,
                         input logic [TW-1:0] d, input logic [TW-1:0] t);
      res[k*XL +: XL] = r;
      rdp[k*TW +: TW] = d;
      tag[k*TW +: TW] = t;
   endtask

   task automatic mdl_reset();
      for (int k = 0; k < N; k++) mq[k].delete();
      m_rr  = 0;
      m_err = 1'b0;
   endtask

   task automatic mdl_out(output logic ev, output int eg, output ent_t ee);
      ev = 1'b0;
      eg = 0;
      ee = '0;
      if (!flush) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_rr + i) % N;
            if (!ev && mq[k].size() != 0) begin
               ev = 1'b1;
               eg = k;
               ee = mq[k][0];
            end
         end
      end
   endtask

   task automatic tick();
      logic   ev;
      int     eg;
      ent_t   ee;
      logic [N-1:0] es;
      #2;
      mdl_out(ev, eg, ee);
      for (int k = 0; k < N; k++) es[k] = (mq[k].size() >= D - 1);
      chk("cdb_valid", cvld, ev);
      chk("cdb_src", csrc, eg);
      chk("cdb_data", {cres, crd, ctag}, ee);
      chk("fu_stall", stall, es);
      chk("overflow_err", err, m_err);
      if (cvld && csrc == 0) obs0.push_back(int'(cres));
      saw_stall0 = saw_stall0 | stall[0];
      last_stall = stall;
      @(posedge clk);
      if (flush) begin
         for (int k = 0; k < N; k++) mq[k].delete();
         m_rr = 0;
      end else begin
         if (ev) begin
            void'(mq[eg].pop_front());
            m_rr = (eg + 1) % N;
         end
         for (int k = 0; k < N; k++) begin
            if (v[k]) begin
               if (mq[k].size() < D)
                  mq[k].push_back({res[k*XL +: XL], rdp[k*TW +: TW],
                                   tag[k*TW +: TW]});
               else
                  m_err = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      v     = '0;
      flush = 1'b0;
      #1;
      chk("rst_valid", cvld, 1'b0);
      chk("rst_stall", stall, '0);
      chk("rst_data", {cres, crd, ctag, csrc}, '0);
      chk("rst_err", err, 1'b0);
      mdl_reset();
      last_stall = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      bit            do_rst;
      logic [N-1:0]  v;
      logic [XL-1:0] r0;
      logic [TW-1:0] d0;
      logic [TW-1:0] t0;
      logic [XL-1:0] r1;
      logic [TW-1:0] d1;
      logic [TW-1:0] t1;
      logic          ev;
      logic [SW-1:0] es;
      logic [XL-1:0] er;
      logic [TW-1:0] ed;
      logic [TW-1:0] et;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int n1;
      int bad;
      int guard;

      tbl[0]  = '{1, 2'b01, 32'h5, 6'd3, 6'd9, 32'h0, 6'd0, 6'd0,
                  1'b0, 1'b0, 32'h0, 6'd0, 6'd0};
      tbl[1]  = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b1, 1'b0, 32'h5, 6'd3, 6'd9};
      tbl[2]  = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b0, 1'b0, 32'h0, 6'd0, 6'd0};
      tbl[3]  = '{1, 2'b11, 32'hA, 6'd1, 6'd2, 32'hB, 6'd4, 6'd5,
                  1'b0, 1'b0, 32'h0, 6'd0, 6'd0};
      tbl[4]  = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b1, 1'b0, 32'hA, 6'd1, 6'd2};
      tbl[5]  = '{0, 2'b11, 32'hC, 6'd6, 6'd7, 32'hD, 6'd8, 6'd10,
                  1'b1, 1'b1, 32'hB, 6'd4, 6'd5};
      tbl[6]  = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b1, 1'b0, 32'hC, 6'd6, 6'd7};
      tbl[7]  = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b1, 1'b1, 32'hD, 6'd8, 6'd10};
      tbl[8]  = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b0, 1'b0, 32'h0, 6'd0, 6'd0};
      tbl[9]  = '{1, 2'b01, 32'h11, 6'd1, 6'd1, 32'h0, 6'd0, 6'd0,
                  1'b0, 1'b0, 32'h0, 6'd0, 6'd0};
      tbl[10] = '{0, 2'b11, 32'h22, 6'd2, 6'd2, 32'h33, 6'd3, 6'd3,
                  1'b1, 1'b0, 32'h11, 6'd1, 6'd1};
      tbl[11] = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b1, 1'b1, 32'h33, 6'd3, 6'd3};
      tbl[12] = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b1, 1'b0, 32'h22, 6'd2, 6'd2};
      tbl[13] = '{0, 2'b00, 32'h0, 6'd0, 6'd0, 32'h0, 6'd0, 6'd0,
                  1'b0, 1'b0, 32'h0, 6'd0, 6'd0};

      #2;
      do_reset();

      // Single result, contention and pointer rotation.
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].do_rst) do_reset();
         v     = tbl[i].v;
         flush = 1'b0;
         set_fu(0, tbl[i].r0, tbl[i].d0, tbl[i].t0);
         set_fu(1, tbl[i].r1, tbl[i].d1, tbl[i].t1);
         #1;
         chk("tbl_valid", cvld, tbl[i].ev);
         chk("tbl_src", csrc, tbl[i].es);
         chk("tbl_data", {cres, crd, ctag},
             {tbl[i].er, tbl[i].ed, tbl[i].et});
         tick();
      end

      // Fill while honouring stall with one op in flight.
      do_reset();
      obs0.delete();
      saw_stall0 = 1'b0;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 40; c++) begin
         v[0] = ~last_stall[0];
         v[1] = ~last_stall[1];
         if (v[0]) begin
            n0++;
            set_fu(0, n0, n0[5:0], 6'd1);
         end
         if (v[1]) begin
            n1++;
            set_fu(1, 32'h100 + n1, n1[5:0], 6'd2);
         end
         tick();
      end
      v = '0;
      repeat (20) tick();
      chk("fill_stall_seen", saw_stall0, 1'b1);
      chk("fill_no_ovf", err, 1'b0);
      chk("fill_count", obs0.size(), n0);
      bad = 0;
      foreach (obs0[i]) if (obs0[i] != i + 1) bad++;
      chk("fill_order", bad, 0);

      // Overflow by ignoring stall; sticky through idle and flush.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         v = 2'b11;
         set_fu(0, 32'h200 + c, 6'(c), 6'd3);
         set_fu(1, 32'h300 + c, 6'(c), 6'd4);
         tick();
      end
      chk("ovf_set", err, 1'b1);
      v = '0;
      repeat (3) tick();
      chk("ovf_sticky", err, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("ovf_after_flush", err, 1'b1);

      // Flush with three entries buffered in FU 0.
      do_reset();
      guard = 0;
      while (mq[0].size() < 3 && guard < 10) begin
         v = 2'b11;
         set_fu(0, 32'h400 + guard, 6'd5, 6'd6);
         set_fu(1, 32'h500 + guard, 6'd7, 6'd8);
         tick();
         guard++;
      end
      chk("flush_prefill", mq[0].size(), 3);
      flush = 1'b1;
      v = 2'b10;
      #1;
      chk("flush_cycle_valid", cvld, 1'b0);
      tick();
      flush = 1'b0;
      v = '0;
      #1;
      chk("flush_next_valid", cvld, 1'b0);
      chk("flush_next_stall", stall, '0);
      tick();
      tick();

      // Asynchronous reset between edges with full FIFOs.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         v = 2'b11;
         set_fu(0, 32'h600 + c, 6'd1, 6'd1);
         set_fu(1, 32'h700 + c, 6'd2, 6'd2);
         tick();
      end
      chk("pre_rst_stall", stall, 2'b11);
      chk("pre_rst_valid", cvld, 1'b1);
      #2;
      do_reset();

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         if (c == 200) do_reset();
         flush = ($urandom_range(0, 19) == 0);
         for (int k = 0; k < N; k++) begin
            logic honor;
            honor = ($urandom_range(0, 9) < 7);
            v[k]  = ($urandom_range(0, 2) != 0) &&
                    !(honor && last_stall[k]);
            set_fu(k, $urandom, 6'($urandom), 6'($urandom));
         end
         tick();
      end
      flush = 1'b0;
      v = '0;
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
